// File: rtl/logic_op_sequencer.sv
// -----------------------------------------------------------------------------
// logic_op_sequencer
//   Issue side of the logic unit. It accepts one logic instruction at a time
//   over a valid/ready handshake and reads the operands from a 4-entry register
//   file. It drives AluOp/A/B to the external logic unit for exactly one cycle,
//   then captures AluResult. The result is written back to the register file
//   and returned on a valid/ready response channel.
//
//   Instruction layout (D = DATA_W):
//     [D+7:D+5] op   [D+4] imm_sel   [D+3:D+2] dst   [D+1:D] src_a
//     [D-1:0]   immediate, or src_b in bits [1:0] when imm_sel = 0
//
// Ports
//   Clk, Rst_n        clock (rising edge), asynchronous active-low reset
//   InstrValid/Ready  instruction handshake (ready only while idle)
//   Instr             instruction word, DATA_W+8 bits
//   AluOp, A, B       operation and operands to the logic unit (quiet outside EXEC)
//   AluResult         combinational result returned by the logic unit
//   RespValid/Ready   response handshake
//   RespData          written-back value (0 on error)
//   RespDst           destination register of the response
//   RespErr           illegal op, nothing written
//   RespZero          RespData == 0
// -----------------------------------------------------------------------------
module logic_op_sequencer #(
   parameter int DATA_W = 8
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              InstrValid,
   output logic              InstrReady,
   input  logic [DATA_W+7:0] Instr,
   output logic [2:0]        AluOp,
   output logic [DATA_W-1:0] A,
   output logic [DATA_W-1:0] B,
   input  logic [DATA_W-1:0] AluResult,
   output logic              RespValid,
   input  logic              RespReady,
   output logic [DATA_W-1:0] RespData,
   output logic [1:0]        RespDst,
   output logic              RespErr,
   output logic              RespZero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_WB   = 2'b10,
      ST_RESP = 2'b11
   } state_t;

   localparam logic [2:0] OP_MOVI    = 3'b110;
   localparam logic [2:0] OP_ILLEGAL = 3'b111;
   localparam logic [DATA_W-1:0] ZERO_W = {DATA_W{1'b0}};

   // Instruction field extraction.
   function automatic logic [2:0] f_op(input logic [DATA_W+7:0] w);
      return w[DATA_W+7:DATA_W+5];
   endfunction

   function automatic logic [1:0] f_dst(input logic [DATA_W+7:0] w);
      return w[DATA_W+3:DATA_W+2];
   endfunction

   function automatic logic [1:0] f_src_a(input logic [DATA_W+7:0] w);
      return w[DATA_W+1:DATA_W];
   endfunction

   // Ops 000..101 go to the logic unit; MOVI and the illegal code do not use it.
   function automatic logic f_uses_alu(input logic [2:0] op);
      return (op != OP_MOVI) && (op != OP_ILLEGAL);
   endfunction

   state_t            state_r;
   logic [DATA_W-1:0] regs_r [4];
   logic [2:0]        op_r;
   logic [1:0]        dst_r;
   logic [DATA_W-1:0] imm_r;
   logic [DATA_W-1:0] result_r;
   logic              err_r;
   logic              instr_ready_r;
   logic [2:0]        alu_op_r;
   logic [DATA_W-1:0] alu_a_r;
   logic [DATA_W-1:0] alu_b_r;
   logic              resp_valid_r;
   logic [DATA_W-1:0] resp_data_r;
   logic [1:0]        resp_dst_r;
   logic              resp_err_r;
   logic              resp_zero_r;

   logic [2:0]        op_s;
   logic [1:0]        dst_s;
   logic [DATA_W-1:0] imm_s;
   logic [DATA_W-1:0] a_s;
   logic [DATA_W-1:0] b_s;

   // Decode the offered instruction and read its operands from the register file.
   always_comb begin
      op_s  = f_op(Instr);
      dst_s = f_dst(Instr);
      imm_s = Instr[DATA_W-1:0];
      a_s   = regs_r[f_src_a(Instr)];
      b_s   = ZERO_W;
      if (Instr[DATA_W+4]) begin
         b_s = imm_s;
      end else begin
         b_s = regs_r[Instr[1:0]];
      end
   end

   // Sequencer FSM, register file and all registered outputs.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_r       <= ST_IDLE;
         for (int i = 0; i < 4; i++) begin
            regs_r[i] <= ZERO_W;
         end
         op_r          <= 3'b000;
         dst_r         <= 2'b00;
         imm_r         <= ZERO_W;
         result_r      <= ZERO_W;
         err_r         <= 1'b0;
         instr_ready_r <= 1'b1;
         alu_op_r      <= 3'b000;
         alu_a_r       <= ZERO_W;
         alu_b_r       <= ZERO_W;
         resp_valid_r  <= 1'b0;
         resp_data_r   <= ZERO_W;
         resp_dst_r    <= 2'b00;
         resp_err_r    <= 1'b0;
         resp_zero_r   <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (InstrValid && instr_ready_r) begin
                  op_r          <= op_s;
                  dst_r         <= dst_s;
                  imm_r         <= imm_s;
                  instr_ready_r <= 1'b0;
                  state_r       <= ST_EXEC;
                  // Operands are launched on the accept edge so they are stable
                  // for the whole EXEC cycle.
                  if (f_uses_alu(op_s)) begin
                     alu_op_r <= op_s;
                     alu_a_r  <= a_s;
                     alu_b_r  <= b_s;
                  end else begin
                     alu_op_r <= 3'b000;
                     alu_a_r  <= ZERO_W;
                     alu_b_r  <= ZERO_W;
                  end
               end else begin
                  instr_ready_r <= 1'b1;
               end
            end
            ST_EXEC: begin
               case (op_r)
                  OP_MOVI: begin
                     result_r <= imm_r;
                     err_r    <= 1'b0;
                  end
                  OP_ILLEGAL: begin
                     result_r <= ZERO_W;
                     err_r    <= 1'b1;
                  end
                  default: begin
                     result_r <= AluResult;
                     err_r    <= 1'b0;
                  end
               endcase
               alu_op_r <= 3'b000;
               alu_a_r  <= ZERO_W;
               alu_b_r  <= ZERO_W;
               state_r  <= ST_WB;
            end
            ST_WB: begin
               if (!err_r) begin
                  regs_r[dst_r] <= result_r;
               end else begin
                  regs_r[dst_r] <= regs_r[dst_r];
               end
               resp_valid_r <= 1'b1;
               resp_data_r  <= result_r;
               resp_dst_r   <= dst_r;
               resp_err_r   <= err_r;
               resp_zero_r  <= (result_r == ZERO_W);
               state_r      <= ST_RESP;
            end
            ST_RESP: begin
               if (RespReady) begin
                  resp_valid_r  <= 1'b0;
                  instr_ready_r <= 1'b1;
                  state_r       <= ST_IDLE;
               end else begin
                  state_r <= ST_RESP;
               end
            end
            default: begin
               state_r       <= ST_IDLE;
               instr_ready_r <= 1'b1;
               resp_valid_r  <= 1'b0;
               alu_op_r      <= 3'b000;
               alu_a_r       <= ZERO_W;
               alu_b_r       <= ZERO_W;
            end
         endcase
      end
   end

   assign InstrReady = instr_ready_r;
   assign AluOp      = alu_op_r;
   assign A          = alu_a_r;
   assign B          = alu_b_r;
   assign RespValid  = resp_valid_r;
   assign RespData   = resp_data_r;
   assign RespDst    = resp_dst_r;
   assign RespErr    = resp_err_r;
   assign RespZero   = resp_zero_r;

endmodule

// File: tb/tb_logic_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_logic_op_sequencer
//   Table of instructions with hand-derived expected responses, pushed to a
//   scoreboard queue when issued and compared when the response appears. It also
//   contains hand-written sequences for response backpressure and mid-EXEC reset.
//   The bench provides a behavioural model of the external logic unit.
// -----------------------------------------------------------------------------
module tb_logic_op_sequencer;

   logic        clk;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [2:0]  alu_op;
   logic [7:0]  a;
   logic [7:0]  b;
   logic [7:0]  alu_result;
   logic        resp_valid;
   logic        resp_ready;
   logic [7:0]  resp_data;
   logic [1:0]  resp_dst;
   logic        resp_err;
   logic        resp_zero;

   logic_op_sequencer #(.DATA_W(8)) dut (
      .Clk        (clk),
      .Rst_n      (rst_n),
      .InstrValid (instr_valid),
      .InstrReady (instr_ready),
      .Instr      (instr),
      .AluOp      (alu_op),
      .A          (a),
      .B          (b),
      .AluResult  (alu_result),
      .RespValid  (resp_valid),
      .RespReady  (resp_ready),
      .RespData   (resp_data),
      .RespDst    (resp_dst),
      .RespErr    (resp_err),
      .RespZero   (resp_zero)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // External logic unit: rotates are by one bit.
   always_comb begin
      case (alu_op)
         3'b000:  alu_result = ~a;
         3'b001:  alu_result = a & b;
         3'b010:  alu_result = a | b;
         3'b011:  alu_result = ~(a & b);
         3'b100:  alu_result = {a[6:0], a[7]};
         3'b101:  alu_result = {a[0], a[7:1]};
         default: alu_result = 8'h00;
      endcase
   end

   typedef struct {
      logic [2:0] op;
      logic       imm_sel;
      logic [1:0] dst;
      logic [1:0] src_a;
      logic [7:0] low;
      logic [7:0] exp_data;
      logic       exp_err;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic [1:0] dst;
      logic       err;
   } resp_t;

   vec_t  vecs [16];
   resp_t sb_q [$];

   int checks_total;
   int checks_passed;

   logic [2:0] s_alu_op;
   logic [7:0] s_a;
   logic [7:0] s_b;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks_total++;
      if (act === exp) begin
         checks_passed++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Offer one instruction, push its expectation, and return at the EXEC negedge
   // with the logic-unit bus sampled into s_alu_op/s_a/s_b.
   task automatic issue(input logic [2:0] op, input logic imm_sel, input logic [1:0] dst,
                        input logic [1:0] src_a, input logic [7:0] low,
                        input logic [7:0] exp_data, input logic exp_err);
      int    n;
      resp_t e;
      n = 0;
      while (!instr_ready && n < 20) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("instr_ready_timeout", {31'd0, instr_ready}, 32'd1);
      instr       = {op, imm_sel, dst, src_a, low};
      instr_valid = 1'b1;
      e.data      = exp_data;
      e.dst       = dst;
      e.err       = exp_err;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      instr       = 16'($urandom);
      @(negedge clk);
      s_alu_op = alu_op;
      s_a      = a;
      s_b      = b;
   endtask

   // Wait for RespValid and report how many negedges after EXEC it appeared.
   task automatic wait_resp(output int lat);
      lat = 0;
      while (!resp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("resp_valid_timeout", {31'd0, resp_valid}, 32'd1);
   endtask

   task automatic pop_check(input string tag);
      resp_t e;
      if (sb_q.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check({tag, "_data"}, {24'd0, resp_data}, {24'd0, e.data});
         check({tag, "_dst"},  {30'd0, resp_dst},  {30'd0, e.dst});
         check({tag, "_err"},  {31'd0, resp_err},  {31'd0, e.err});
         check({tag, "_zero"}, {31'd0, resp_zero}, {31'd0, (e.data == 8'h00)});
      end
   endtask

   // Complete an issued instruction with RespReady high: latency, response
   // fields, quiet bus in RESP, and return to idle after the handshake.
   task automatic finish(input string tag);
      int lat;
      wait_resp(lat);
      check({tag, "_latency"}, lat, 32'd2);
      pop_check(tag);
      check({tag, "_quiet_bus"}, {21'd0, alu_op, a, b}, 32'd0);
      @(posedge clk);
      #1;
      check({tag, "_idle"}, {30'd0, resp_valid, instr_ready}, 32'd1);
   endtask

   task automatic run(input logic [2:0] op, input logic imm_sel, input logic [1:0] dst,
                      input logic [1:0] src_a, input logic [7:0] low,
                      input logic [7:0] exp_data, input logic exp_err, input string tag);
      issue(op, imm_sel, dst, src_a, low, exp_data, exp_err);
      finish(tag);
   endtask

   initial begin
      int lat;
      checks_total  = 0;
      checks_passed = 0;

      //             op      imm   dst   srcA  low    data   err
      vecs[0]  = '{3'b110, 1'b0, 2'd1, 2'd0, 8'hF0, 8'hF0, 1'b0}; // MOVI R1,F0
      vecs[1]  = '{3'b110, 1'b0, 2'd2, 2'd0, 8'h3C, 8'h3C, 1'b0}; // MOVI R2,3C
      vecs[2]  = '{3'b001, 1'b0, 2'd3, 2'd1, 8'h02, 8'h30, 1'b0}; // AND R3,R1,R2
      vecs[3]  = '{3'b010, 1'b1, 2'd0, 2'd1, 8'h0F, 8'hFF, 1'b0}; // OR R0,R1,#0F
      vecs[4]  = '{3'b110, 1'b0, 2'd1, 2'd0, 8'hFF, 8'hFF, 1'b0}; // MOVI R1,FF
      vecs[5]  = '{3'b011, 1'b0, 2'd2, 2'd1, 8'h01, 8'h00, 1'b0}; // NAND R2,R1,R1
      vecs[6]  = '{3'b000, 1'b0, 2'd2, 2'd2, 8'h00, 8'hFF, 1'b0}; // NOT R2,R2
      vecs[7]  = '{3'b100, 1'b0, 2'd0, 2'd3, 8'h00, 8'h60, 1'b0}; // LR R0,R3
      vecs[8]  = '{3'b101, 1'b0, 2'd0, 2'd3, 8'h00, 8'h18, 1'b0}; // RR R0,R3
      vecs[9]  = '{3'b111, 1'b0, 2'd3, 2'd0, 8'hAB, 8'h00, 1'b1}; // illegal, dst R3
      vecs[10] = '{3'b010, 1'b1, 2'd0, 2'd3, 8'h00, 8'h30, 1'b0}; // OR R0,R3,#00
      vecs[11] = '{3'b110, 1'b0, 2'd2, 2'd0, 8'h81, 8'h81, 1'b0}; // MOVI R2,81
      vecs[12] = '{3'b101, 1'b0, 2'd2, 2'd2, 8'h00, 8'hC0, 1'b0}; // RR R2,R2
      vecs[13] = '{3'b100, 1'b0, 2'd1, 2'd2, 8'h00, 8'h81, 1'b0}; // LR R1,R2
      vecs[14] = '{3'b001, 1'b0, 2'd3, 2'd0, 8'h01, 8'h00, 1'b0}; // AND R3,R0,R1
      vecs[15] = '{3'b010, 1'b1, 2'd3, 2'd3, 8'hA5, 8'hA5, 1'b0}; // OR R3,R3,#A5

      rst_n       = 1'b1;
      instr_valid = 1'b0;
      instr       = 16'h0000;
      resp_ready  = 1'b1;
      #3;
      rst_n = 1'b0;
      #20;
      check("reset_outputs", {8'd0, resp_valid, resp_data, resp_dst, resp_err, resp_zero,
                              alu_op, a, b}, 32'd0);
      check("reset_instr_ready", {31'd0, instr_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 16; i++) begin
         issue(vecs[i].op, vecs[i].imm_sel, vecs[i].dst, vecs[i].src_a, vecs[i].low,
               vecs[i].exp_data, vecs[i].exp_err);
         if (i == 3) begin
            check("or_imm_bus", {13'd0, s_alu_op, s_a, s_b}, {13'd0, 3'b010, 8'hF0, 8'h0F});
         end else begin
            check("exec_op", {29'd0, s_alu_op},
                  {29'd0, (vecs[i].op >= 3'b110) ? 3'b000 : vecs[i].op});
         end
         finish($sformatf("vec%0d", i));
      end

      // Backpressure: response held for 5 cycles, and an offered instruction is ignored.
      resp_ready = 1'b0;
      issue(3'b110, 1'b0, 2'd0, 2'd0, 8'h5A, 8'h5A, 1'b0);   // MOVI R0,5A
      wait_resp(lat);
      check("bp_latency", lat, 32'd2);
      for (int k = 0; k < 5; k++) begin
         instr_valid = 1'b1;
         instr       = {3'b110, 1'b0, 2'd1, 2'd0, 8'h11};     // MOVI R1,11 (ignored)
         @(negedge clk);
         check("bp_hold", {15'd0, resp_valid, resp_data, resp_dst, resp_err, resp_zero,
                           instr_ready, alu_op},
               {15'd0, 1'b1, 8'h5A, 2'd0, 1'b0, 1'b0, 1'b0, 3'b000});
      end
      instr_valid = 1'b0;
      resp_ready  = 1'b1;
      pop_check("bp");
      @(posedge clk);
      #1;
      check("bp_release", {30'd0, resp_valid, instr_ready}, 32'd1);
      run(3'b010, 1'b1, 2'd2, 2'd1, 8'h00, 8'h81, 1'b0, "bp_r1_kept");
      run(3'b010, 1'b1, 2'd3, 2'd0, 8'h00, 8'h5A, 1'b0, "bp_r0_written");

      // Reset in the middle of EXEC: everything clears, nothing is written or returned.
      issue(3'b110, 1'b0, 2'd2, 2'd0, 8'h77, 8'h77, 1'b0);   // MOVI R2,77
      void'(sb_q.pop_back());
      rst_n = 1'b0;
      #1;
      check("rst_exec_outputs", {8'd0, resp_valid, resp_data, resp_dst, resp_err, resp_zero,
                                 alu_op, a, b}, 32'd0);
      check("rst_exec_ready", {31'd0, instr_ready}, 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check("rst_no_resp", {31'd0, resp_valid}, 32'd0);
      end
      @(posedge clk);
      #1;
      run(3'b010, 1'b1, 2'd0, 2'd2, 8'h00, 8'h00, 1'b0, "rst_r2_clear");
      run(3'b010, 1'b1, 2'd0, 2'd3, 8'h00, 8'h00, 1'b0, "rst_r3_clear");

      check("sb_drained", sb_q.size(), 32'd0);
      $display("%0d/%0d checks passed", checks_passed, checks_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
